muldiv_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide operations, sitting beside the single-cycle ALU in the execute stage. It accepts one M-extension operation at a time through a valid/ready handshake. It runs multiplies in a short fixed latency and divides/remainders with an iterative 32-step restoring divider. It returns the result with the destination tag through a valid/ready response port and raises `busy` so the pipeline can stall.

---
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_ctrl.sv | 121 ++++++++++++
 tb/tb_muldiv_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the M-extension sequencer.
// The master side is the pipeline; the slave side is muldiv_ctrl.
interface muldiv_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic [4:0]  resp_rd;
  logic        busy;
  logic        flush;

  modport master (
    output req_valid, req_op, req_op1, req_op2, req_rd, resp_ready, flush,
    input  req_ready, resp_valid, resp_result, resp_rd, busy
  );

  modport slave (
    input  req_valid, req_op, req_op1, req_op2, req_rd, resp_ready, flush,
    output req_ready, resp_valid, resp_result, resp_rd, busy
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// RV32M multiply/divide sequencer: one-cycle multiply, 32-step restoring divide,
// divide-by-zero and signed overflow resolved at acceptance.
module muldiv_ctrl (
  input logic      clk,
  input logic      rst,
  muldiv_if.slave  mdu
);
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [31:0] op1_q;   // multiplicand, or dividend shifting out / quotient shifting in
  logic [31:0] op2_q;
  logic [31:0] rem_q;
  logic [4:0]  cnt_q;
  logic        neg_quo_q, neg_rem_q;
  logic [31:0] resp_result_q;
  logic [4:0]  resp_rd_q;

  logic        accept, sgn_div, div_zero, div_ovf, special;
  logic [31:0] special_result, dvd_abs, dvs_abs;

  always_comb begin
    accept   = mdu.req_valid & mdu.req_ready;
    sgn_div  = ~mdu.req_op[0];
    div_zero = (mdu.req_op2 == '0);
    div_ovf  = sgn_div & (mdu.req_op1 == 32'h8000_0000) & (mdu.req_op2 == '1);
    special  = mdu.req_op[2] & (div_zero | div_ovf);
    if (div_zero) special_result = mdu.req_op[1] ? mdu.req_op1 : '1;
    else          special_result = mdu.req_op[1] ? '0 : 32'h8000_0000;
    dvd_abs = (sgn_div & mdu.req_op1[31]) ? -mdu.req_op1 : mdu.req_op1;
    dvs_abs = (sgn_div & mdu.req_op2[31]) ? -mdu.req_op2 : mdu.req_op2;
  end

  logic               mul_s1, mul_s2;
  logic signed [32:0] mul_a, mul_b;
  logic signed [63:0] prod;

  always_comb begin
    mul_s1 = (op_q == 2'b01) || (op_q == 2'b10);
    mul_s2 = (op_q == 2'b01);
    mul_a  = {mul_s1 & op1_q[31], op1_q};
    mul_b  = {mul_s2 & op2_q[31], op2_q};
    prod   = 64'(mul_a) * 64'(mul_b);
  end

  logic [32:0] part;
  logic        no_borrow;
  logic [31:0] rem_next;

  always_comb begin
    part      = {rem_q, op1_q[31]};
    no_borrow = (part >= {1'b0, op2_q});
    rem_next  = no_borrow ? (part[31:0] - op2_q) : part[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = !mdu.req_op[2] ? S_MUL : (special ? S_DONE : S_DIV);
      S_MUL:   state_d = S_DONE;
      S_DIV:   if (cnt_q == '0) state_d = S_FIXUP;
      S_FIXUP: state_d = S_DONE;
      S_DONE:  if (mdu.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (mdu.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q          <= '0;
      op1_q         <= '0;
      op2_q         <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      resp_result_q <= '0;
      resp_rd_q     <= '0;
    end else if (mdu.flush) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (accept) begin
          op_q      <= mdu.req_op[1:0];
          op1_q     <= mdu.req_op[2] ? dvd_abs : mdu.req_op1;
          op2_q     <= mdu.req_op[2] ? dvs_abs : mdu.req_op2;
          rem_q     <= '0;
          cnt_q     <= 5'd31;
          neg_quo_q <= sgn_div & (mdu.req_op1[31] ^ mdu.req_op2[31]);
          neg_rem_q <= sgn_div & mdu.req_op1[31];
          resp_rd_q <= mdu.req_rd;
          if (special) resp_result_q <= special_result;
        end
        S_MUL: resp_result_q <= (op_q == 2'b00) ? prod[31:0] : prod[63:32];
        S_DIV: begin
          rem_q <= rem_next;
          op1_q <= {op1_q[30:0], no_borrow};
          cnt_q <= cnt_q - 5'd1;
        end
        S_FIXUP: begin
          if (op_q[1]) resp_result_q <= neg_rem_q ? -rem_q : rem_q;
          else         resp_result_q <= neg_quo_q ? -op1_q : op1_q;
        end
        default: ;
      endcase
    end
  end

  assign mdu.req_ready   = (state_q == S_IDLE) & ~mdu.flush;
  assign mdu.resp_valid  = (state_q == S_DONE);
  assign mdu.busy        = (state_q != S_IDLE);
  assign mdu.resp_result = resp_result_q;
  assign mdu.resp_rd     = resp_rd_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  muldiv_if mdu();
  muldiv_ctrl dut (.clk(clk), .rst(rst), .mdu(mdu));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; if (ovf) return 32'h8000_0000; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin if (b == 0) return a; if (ovf) return 32'h0; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 1;
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 0;
    return 33;
  endfunction

  // Presents one request, then counts negedges after the acceptance edge until resp_valid.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       output int lat, output logic busy_ok, output logic acc_ok);
    @(negedge clk);
    acc_ok = mdu.req_ready;
    mdu.req_valid = 1'b1; mdu.req_op = op; mdu.req_op1 = a; mdu.req_op2 = b; mdu.req_rd = rd;
    @(negedge clk);
    mdu.req_valid = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!mdu.resp_valid && lat < 100) begin
      if (!mdu.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    mdu.resp_ready = 1'b1;
    @(negedge clk);
    mdu.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    total++; if (mdu.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b expected 0", mdu.resp_valid); else passed++;
    total++; if (mdu.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", mdu.busy); else passed++;
    total++; if (mdu.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", mdu.req_ready); else passed++;
    total++; if (mdu.resp_result !== 32'h0) $display("FAIL reset_result: got %h expected 0", mdu.resp_result); else passed++;
    total++; if (mdu.resp_rd !== 5'h0) $display("FAIL reset_rd: got %h expected 0", mdu.resp_rd); else passed++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_ops(input string name, input int n_rand, input int kind,
                          input logic [2:0] d_op[4], input logic [31:0] d_a[4], input logic [31:0] d_b[4],
                          input logic [31:0] d_exp[4]);
    logic [2:0] op; logic [31:0] a, b, exp; logic [4:0] rd;
    int lat, exp_lat; logic busy_ok, acc_ok;
    for (int i = 0; i < 4 + n_rand; i++) begin
      if (i < 4) begin
        op = d_op[i]; a = d_a[i]; b = d_b[i]; exp = d_exp[i];
      end else begin
        a = $urandom;
        b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
        if (kind == 0) op = 3'($urandom_range(0, 3));
        else op = 3'($urandom_range(4, 7));
        if (kind == 2) begin
          if ($urandom_range(0, 1) == 0) b = 32'h0;
          else begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; op = $urandom_range(0, 1) ? 3'd4 : 3'd6; end
        end
        exp = ref_result(op, a, b);
      end
      exp_lat = ref_latency(op, a, b);
      rd = 5'($urandom_range(0, 31));
      issue(op, a, b, rd, lat, busy_ok, acc_ok);
      total++; if (acc_ok !== 1'b1) $display("FAIL %s_req_ready[%0d]: got %b expected 1", name, i, acc_ok); else passed++;
      total++; if (lat != exp_lat) $display("FAIL %s_latency[%0d] op=%0d: got %0d expected %0d", name, i, op, lat, exp_lat); else passed++;
      total++; if (mdu.resp_result !== exp) $display("FAIL %s_result[%0d] op=%0d a=%h b=%h: got %h expected %h", name, i, op, a, b, mdu.resp_result, exp); else passed++;
      total++; if (mdu.resp_rd !== rd) $display("FAIL %s_rd[%0d]: got %h expected %h", name, i, mdu.resp_rd, rd); else passed++;
      total++; if (busy_ok !== 1'b1 || mdu.busy !== 1'b1) $display("FAIL %s_busy[%0d]: got %b expected 1", name, i, busy_ok & mdu.busy); else passed++;
      consume();
      total++; if (mdu.resp_valid !== 1'b0 || mdu.req_ready !== 1'b1) $display("FAIL %s_release[%0d]: got valid=%b ready=%b expected valid=0 ready=1", name, i, mdu.resp_valid, mdu.req_ready); else passed++;
    end
  endtask

  task automatic test_mul();
    logic [2:0]  op[4]  = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] a[4]   = '{32'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b[4]   = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
    logic [31:0] e[4]   = '{32'h0000_002D, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    test_ops("mul", 20, 0, op, a, b, e);
  endtask

  task automatic test_div();
    logic [2:0]  op[4]  = '{3'd5, 3'd4, 3'd6, 3'd7};
    logic [31:0] a[4]   = '{32'd100, 32'hFFFF_FF95, 32'hFFFF_FF95, 32'd107};
    logic [31:0] b[4]   = '{32'd10, 32'd10, 32'd10, 32'd10};
    logic [31:0] e[4]   = '{32'd10, 32'hFFFF_FFF6, 32'hFFFF_FFF9, 32'd7};
    test_ops("div", 30, 1, op, a, b, e);
  endtask

  task automatic test_special();
    logic [2:0]  op[4]  = '{3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] a[4]   = '{32'd100, 32'd107, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b[4]   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e[4]   = '{32'hFFFF_FFFF, 32'd107, 32'h8000_0000, 32'h0};
    test_ops("special", 8, 2, op, a, b, e);
  endtask

  task automatic test_backpressure();
    logic [31:0] a = $urandom, b = 32'($urandom_range(1, 1000)), exp;
    int lat; logic busy_ok, acc_ok;
    exp = ref_result(3'd4, a, b);
    issue(3'd4, a, b, 5'h1F, lat, busy_ok, acc_ok);
    total++; if (lat != 33) $display("FAIL bp_latency: got %0d expected 33", lat); else passed++;
    for (int i = 0; i < 5; i++) begin
      mdu.req_valid = 1'b1; mdu.req_op = 3'($urandom_range(0, 7));
      mdu.req_op1 = $urandom; mdu.req_op2 = $urandom; mdu.req_rd = 5'h05;
      @(negedge clk);
      total++; if (mdu.resp_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b expected 1", i, mdu.resp_valid); else passed++;
      total++; if (mdu.resp_result !== exp) $display("FAIL bp_result[%0d]: got %h expected %h", i, mdu.resp_result, exp); else passed++;
      total++; if (mdu.resp_rd !== 5'h1F) $display("FAIL bp_rd[%0d]: got %h expected 1f", i, mdu.resp_rd); else passed++;
      total++; if (mdu.req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, mdu.req_ready); else passed++;
    end
    mdu.req_valid = 1'b0;
    consume();
    total++; if (mdu.resp_valid !== 1'b0 || mdu.busy !== 1'b0 || mdu.req_ready !== 1'b1)
      $display("FAIL bp_release: got valid=%b busy=%b ready=%b expected 0 0 1", mdu.resp_valid, mdu.busy, mdu.req_ready);
    else passed++;
  endtask

  task automatic test_flush();
    int pulses = 0, lat; logic busy_ok, acc_ok;
    @(negedge clk);
    mdu.req_valid = 1'b1; mdu.req_op = 3'd4; mdu.req_op1 = 32'd12345; mdu.req_op2 = 32'd7; mdu.req_rd = 5'h11;
    @(negedge clk);
    mdu.req_valid = 1'b0;
    repeat (9) @(negedge clk);
    mdu.flush = 1'b1;
    mdu.req_valid = 1'b1; mdu.req_op = 3'd0; mdu.req_op1 = 32'd9; mdu.req_op2 = 32'd9; mdu.req_rd = 5'h12;
    #1;
    total++; if (mdu.req_ready !== 1'b0) $display("FAIL flush_req_ready: got %b expected 0", mdu.req_ready); else passed++;
    @(negedge clk);
    mdu.flush = 1'b0; mdu.req_valid = 1'b0;
    total++; if (mdu.busy !== 1'b0 || mdu.resp_valid !== 1'b0) $display("FAIL flush_idle: got busy=%b valid=%b expected 0 0", mdu.busy, mdu.resp_valid); else passed++;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mdu.resp_valid || mdu.busy) pulses++;
    end
    total++; if (pulses != 0) $display("FAIL flush_no_resp: got %0d active cycles expected 0", pulses); else passed++;
    issue(3'd0, 32'd200, 32'd100, 5'h0A, lat, busy_ok, acc_ok);
    total++; if (lat != 1) $display("FAIL flush_mul_latency: got %0d expected 1", lat); else passed++;
    total++; if (mdu.resp_result !== 32'd20000) $display("FAIL flush_mul_result: got %h expected %h", mdu.resp_result, 32'd20000); else passed++;
    total++; if (mdu.resp_rd !== 5'h0A) $display("FAIL flush_mul_rd: got %h expected 0a", mdu.resp_rd); else passed++;
    consume();
  endtask

  task automatic test_reset_mid();
    int lat; logic busy_ok, acc_ok;
    @(negedge clk);
    mdu.req_valid = 1'b1; mdu.req_op = 3'd5; mdu.req_op1 = 32'd999; mdu.req_op2 = 32'd3; mdu.req_rd = 5'h07;
    @(negedge clk);
    mdu.req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (mdu.busy !== 1'b0 || mdu.resp_valid !== 1'b0) $display("FAIL rstmid_state: got busy=%b valid=%b expected 0 0", mdu.busy, mdu.resp_valid); else passed++;
    total++; if (mdu.resp_result !== 32'h0 || mdu.resp_rd !== 5'h0) $display("FAIL rstmid_outputs: got result=%h rd=%h expected 0 0", mdu.resp_result, mdu.resp_rd); else passed++;
    total++; if (mdu.req_ready !== 1'b1) $display("FAIL rstmid_req_ready: got %b expected 1", mdu.req_ready); else passed++;
    @(negedge clk);
    rst = 1'b0;
    issue(3'd5, 32'd100, 32'd10, 5'h03, lat, busy_ok, acc_ok);
    total++; if (lat != 33) $display("FAIL rstmid_div_latency: got %0d expected 33", lat); else passed++;
    total++; if (mdu.resp_result !== 32'd10) $display("FAIL rstmid_div_result: got %h expected %h", mdu.resp_result, 32'd10); else passed++;
    total++; if (mdu.resp_rd !== 5'h03) $display("FAIL rstmid_div_rd: got %h expected 03", mdu.resp_rd); else passed++;
    consume();
  endtask

  initial begin
    mdu.req_valid = 1'b0; mdu.req_op = '0; mdu.req_op1 = '0; mdu.req_op2 = '0;
    mdu.req_rd = '0; mdu.resp_ready = 1'b0; mdu.flush = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
